// File: rtl/ex_mem_reg_if.sv
// EX/MEM stage boundary bundle: EX-side results in, registered MEM-side copies out.
// master = EX stage / driver, slave = the pipeline register itself.
interface ex_mem_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WB_W       = 2
);
  logic [WB_W-1:0]       EX_wb;
  logic [2:0]            EX_m;
  logic [DATA_W-1:0]     EX_branch_target;
  logic                  EX_zero;
  logic [DATA_W-1:0]     EX_alu_result;
  logic [DATA_W-1:0]     EX_reg_data2;
  logic [REG_ADDR_W-1:0] EX_mux_out;

  logic [WB_W-1:0]       MEM_wb;
  logic                  MEM_branch;
  logic                  MEM_mem_read;
  logic                  MEM_mem_write;
  logic [DATA_W-1:0]     MEM_branch_target;
  logic                  MEM_zero;
  logic [DATA_W-1:0]     MEM_alu_result;
  logic [DATA_W-1:0]     MEM_reg_data2;
  logic [REG_ADDR_W-1:0] MEM_mux_out;

  modport master (
    output EX_wb, EX_m, EX_branch_target, EX_zero, EX_alu_result, EX_reg_data2, EX_mux_out,
    input  MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target, MEM_zero,
           MEM_alu_result, MEM_reg_data2, MEM_mux_out
  );

  modport slave (
    input  EX_wb, EX_m, EX_branch_target, EX_zero, EX_alu_result, EX_reg_data2, EX_mux_out,
    output MEM_wb, MEM_branch, MEM_mem_read, MEM_mem_write, MEM_branch_target, MEM_zero,
           MEM_alu_result, MEM_reg_data2, MEM_mux_out
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results every rising edge, presents them to MEM.
// Synchronous active-low clear via startin; the 3-bit M field is split into MEM strobes.
module ex_mem_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned WB_W       = 2
) (
  input  logic          clk,
  input  logic          startin,
  ex_mem_reg_if.slave   bus
);

  logic [WB_W-1:0]       wb_q;
  logic                  branch_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [DATA_W-1:0]     branch_target_q;
  logic                  zero_q;
  logic [DATA_W-1:0]     alu_result_q;
  logic [DATA_W-1:0]     reg_data2_q;
  logic [REG_ADDR_W-1:0] mux_out_q;

  // Clear dominates capture; no enable, so a new value lands every cycle otherwise.
  always_ff @(posedge clk) begin
    if (!startin) begin
      wb_q            <= '0;
      branch_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
      alu_result_q    <= '0;
      reg_data2_q     <= '0;
      mux_out_q       <= '0;
    end else begin
      wb_q            <= bus.EX_wb;
      branch_q        <= bus.EX_m[2];
      mem_read_q      <= bus.EX_m[1];
      mem_write_q     <= bus.EX_m[0];
      branch_target_q <= bus.EX_branch_target;
      zero_q          <= bus.EX_zero;
      alu_result_q    <= bus.EX_alu_result;
      reg_data2_q     <= bus.EX_reg_data2;
      mux_out_q       <= bus.EX_mux_out;
    end
  end

  assign bus.MEM_wb            = wb_q;
  assign bus.MEM_branch        = branch_q;
  assign bus.MEM_mem_read      = mem_read_q;
  assign bus.MEM_mem_write     = mem_write_q;
  assign bus.MEM_branch_target = branch_target_q;
  assign bus.MEM_zero          = zero_q;
  assign bus.MEM_alu_result    = alu_result_q;
  assign bus.MEM_reg_data2     = reg_data2_q;
  assign bus.MEM_mux_out       = mux_out_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, corner sequences, random stream.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        startin;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  mux;
  } in_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  mux;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk;
  logic startin;
  int   passed;
  int   total;

  ex_mem_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2)) bus ();

  ex_mem_reg #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2)) dut (
    .clk     (clk),
    .startin (startin),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic in_t mk_in(logic s, logic [1:0] wb, logic [2:0] m, logic [31:0] tgt,
                                logic z, logic [31:0] alu, logic [31:0] d2, logic [4:0] mux);
    in_t r;
    r.startin = s; r.wb = wb; r.m = m; r.tgt = tgt;
    r.zero = z; r.alu = alu; r.d2 = d2; r.mux = mux;
    return r;
  endfunction

  function automatic out_t mk_out(logic [1:0] wb, logic br, logic rd, logic wr,
                                  logic [31:0] tgt, logic z, logic [31:0] alu,
                                  logic [31:0] d2, logic [4:0] mux);
    out_t r;
    r.wb = wb; r.branch = br; r.mem_read = rd; r.mem_write = wr; r.tgt = tgt;
    r.zero = z; r.alu = alu; r.d2 = d2; r.mux = mux;
    return r;
  endfunction

  // Reference: an edge with startin low yields all-zero; otherwise a field-wise copy.
  function automatic out_t model(in_t v);
    if (!v.startin) return '0;
    return mk_out(v.wb, v.m[2], v.m[1], v.m[0], v.tgt, v.zero, v.alu, v.d2, v.mux);
  endfunction

  function automatic in_t rand_in(logic s);
    return mk_in(s, 2'($urandom), 3'($urandom), $urandom, 1'($urandom), $urandom,
                 $urandom, 5'($urandom));
  endfunction

  task automatic drive(input in_t v);
    startin              = v.startin;
    bus.EX_wb            = v.wb;
    bus.EX_m             = v.m;
    bus.EX_branch_target = v.tgt;
    bus.EX_zero          = v.zero;
    bus.EX_alu_result    = v.alu;
    bus.EX_reg_data2     = v.d2;
    bus.EX_mux_out       = v.mux;
  endtask

  function automatic out_t cur_out();
    return mk_out(bus.MEM_wb, bus.MEM_branch, bus.MEM_mem_read, bus.MEM_mem_write,
                  bus.MEM_branch_target, bus.MEM_zero, bus.MEM_alu_result,
                  bus.MEM_reg_data2, bus.MEM_mux_out);
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = cur_out();
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive on the negedge, sample 1 ns after the following posedge.
  task automatic step(input in_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  in_t  held;
  out_t snap;
  out_t q[$];

  initial begin
    passed = 0;
    total  = 0;
    drive('0);

    vecs[0] = '{in: '0, exp: '0};
    vecs[1] = '{in: mk_in(1'b0, 2'b01, 3'b110, 32'h10, 1'b1, 32'hDEADBEEF, 32'hCAFEBABE,
                          5'b10101), exp: '0};
    vecs[2] = '{in: mk_in(1'b1, 2'b01, 3'b110, 32'h10, 1'b1, 32'hDEADBEEF, 32'hCAFEBABE,
                          5'b10101),
                exp: mk_out(2'b01, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'hDEADBEEF,
                            32'hCAFEBABE, 5'b10101)};
    vecs[3] = '{in: mk_in(1'b0, 2'b11, 3'b101, 32'h20, 1'b0, 32'h12345678, 32'h87654321,
                          5'b01010), exp: '0};
    vecs[4] = '{in: mk_in(1'b1, 2'b11, 3'b101, 32'h20, 1'b0, 32'h12345678, 32'h87654321,
                          5'b01010),
                exp: mk_out(2'b11, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h12345678,
                            32'h87654321, 5'b01010)};
    vecs[5] = '{in: mk_in(1'b1, 2'b10, 3'b011, 32'h30, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0,
                          5'b11111),
                exp: mk_out(2'b10, 1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 32'h0F0F0F0F,
                            32'hF0F0F0F0, 5'b11111)};

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Inputs wiggle mid-cycle with startin high: outputs must hold until the next edge.
    snap = vecs[5].exp;
    #3;
    drive(rand_in(1'b1));
    #4;
    check("hold_mid_cycle", snap);

    // startin dropped between edges must not clear before the edge.
    @(negedge clk);
    held = rand_in(1'b0);
    drive(held);
    #5;
    check("no_async_clear", snap);
    @(posedge clk);
    #1;
    check("sync_clear", '0);

    // Four-cycle stream: each output trails its input by exactly one edge.
    for (int i = 0; i < 4; i++) begin
      held = mk_in(1'b1, 2'(i), 3'(i + 3), 32'h100 + 32'(i), 1'(i), 32'hA000_0000 + 32'(i),
                   32'hB000_0000 + 32'(i), 5'(i * 7));
      step(held);
      check($sformatf("stream%0d", i), model(held));
    end

    // Random stream with occasional clears, checked against a queued reference.
    for (int i = 0; i < 200; i++) begin
      held = rand_in(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
      q.push_back(model(held));
      step(held);
      check($sformatf("rand%0d", i), q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
